// File: rtl/alu_unit.sv
// Integer execute stage: registers one RV32I ALU / branch-compare result per fired op.
// Results appear one rdy-cycle after capture on the ALU broadcast bus.
module alu_unit #(
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              rs_shot,
  input  logic [31:0]       alu_r1,
  input  logic [31:0]       alu_r2,
  input  logic [ROB_W-1:0]  alu_rob_id,
  input  logic [TYPE_W-1:0] alu_work_type,
  output logic              alu_ready,
  output logic [ROB_W-1:0]  inputalu_rob_id,
  output logic [31:0]       alu_value
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BLT  = 4'd12,
    OP_BGE  = 4'd13,
    OP_BLTU = 4'd14,
    OP_BGEU = 4'd15
  } op_e;

  op_e         op;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic [31:0] result;

  assign op    = op_e'(alu_work_type[3:0]);
  assign shamt = alu_r2[4:0];
  assign lt_s  = $signed(alu_r1) < $signed(alu_r2);
  assign lt_u  = alu_r1 < alu_r2;
  assign eq    = alu_r1 == alu_r2;

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = alu_r1 + alu_r2;
      OP_SUB:  result = alu_r1 - alu_r2;
      OP_AND:  result = alu_r1 & alu_r2;
      OP_OR:   result = alu_r1 | alu_r2;
      OP_XOR:  result = alu_r1 ^ alu_r2;
      OP_SLL:  result = alu_r1 << shamt;
      OP_SRL:  result = alu_r1 >> shamt;
      OP_SRA:  result = $unsigned($signed(alu_r1) >>> shamt);
      OP_SLT:  result = {31'd0, lt_s};
      OP_SLTU: result = {31'd0, lt_u};
      OP_BEQ:  result = {31'd0, eq};
      OP_BNE:  result = {31'd0, ~eq};
      OP_BLT:  result = {31'd0, lt_s};
      OP_BGE:  result = {31'd0, ~lt_s};
      OP_BLTU: result = {31'd0, lt_u};
      OP_BGEU: result = {31'd0, ~lt_u};
      default: result = '0;
    endcase
  end

  // Bubbles only drop alu_ready; id/value keep their last contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ready       <= 1'b0;
      inputalu_rob_id <= '0;
      alu_value       <= '0;
    end else if (rdy) begin
      if (clear) begin
        alu_ready <= 1'b0;
      end else if (rs_shot) begin
        alu_ready       <= 1'b1;
        inputalu_rob_id <= alu_rob_id;
        alu_value       <= result;
      end else begin
        alu_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases followed by randomized traffic
// compared against a behavioural model of the execute stage.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, rs_shot;
  logic [31:0] alu_r1, alu_r2;
  logic [3:0]  alu_rob_id, alu_work_type;
  logic        alu_ready;
  logic [3:0]  inputalu_rob_id;
  logic [31:0] alu_value;

  int total = 0;
  int bad   = 0;

  logic        m_ready;
  logic [3:0]  m_id;
  logic [31:0] m_val;

  alu_unit #(.ROB_W(4), .TYPE_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .rs_shot(rs_shot),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_rob_id(alu_rob_id),
    .alu_work_type(alu_work_type), .alu_ready(alu_ready),
    .inputalu_rob_id(inputalu_rob_id), .alu_value(alu_value)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    int unsigned s;
    logic [31:0] all1;
    sa   = int'(a);
    sb   = int'(b);
    s    = b % 32;
    all1 = 32'hFFFF_FFFF;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << s;
      6:  return a >> s;
      7:  return (a >> s) | ((a >= 32'h8000_0000) ? ~(all1 >> s) : 32'd0);
      8:  return (sa < sb) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return (a != b) ? 32'd1 : 32'd0;
      12: return (sa < sb) ? 32'd1 : 32'd0;
      13: return (sa >= sb) ? 32'd1 : 32'd0;
      14: return (a < b) ? 32'd1 : 32'd0;
      default: return (a >= b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, update model, check all outputs.
  task automatic step(input string tag, input logic r, input logic en, input logic cl,
                      input logic sh, input int op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] id);
    rst = r; rdy = en; clear = cl; rs_shot = sh;
    alu_work_type = 4'(op); alu_r1 = a; alu_r2 = b; alu_rob_id = id;
    @(posedge clk);
    #1;
    if (r) begin
      m_ready = 1'b0; m_id = '0; m_val = '0;
    end else if (en) begin
      if (cl || !sh) m_ready = 1'b0;
      else begin
        m_ready = 1'b1; m_id = id; m_val = ref_alu(op, a, b);
      end
    end
    chk({tag, ".ready"}, {31'd0, alu_ready}, {31'd0, m_ready});
    chk({tag, ".id"}, {28'd0, inputalu_rob_id}, {28'd0, m_id});
    chk({tag, ".value"}, alu_value, m_val);
  endtask

  initial begin
    m_ready = 1'b0; m_id = '0; m_val = '0;
    step("reset", 1, 1, 0, 0, 0, 0, 0, 0);
    step("reset2", 1, 0, 0, 1, 0, 32'h1234, 1, 7);

    step("add", 0, 1, 0, 1, 0, 5, 7, 3);
    chk("add.lit", alu_value, 32'd12);
    step("idle", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("idle.lit", {31'd0, alu_ready}, 32'd0);

    step("sub", 0, 1, 0, 1, 1, 0, 1, 1);
    chk("sub.lit", alu_value, 32'hFFFF_FFFF);
    step("sra", 0, 1, 0, 1, 7, 32'h8000_0000, 32'h21, 2);
    chk("sra.lit", alu_value, 32'hC000_0000);
    step("srl", 0, 1, 0, 1, 6, 32'h8000_0000, 32'h21, 2);
    chk("srl.lit", alu_value, 32'h4000_0000);
    step("slt", 0, 1, 0, 1, 8, 32'hFFFF_FFFF, 1, 4);
    chk("slt.lit", alu_value, 32'd1);
    step("sltu", 0, 1, 0, 1, 9, 32'hFFFF_FFFF, 1, 4);
    chk("sltu.lit", alu_value, 32'd0);
    step("bgeu", 0, 1, 0, 1, 15, 32'hFFFF_FFFF, 1, 4);
    chk("bgeu.lit", alu_value, 32'd1);
    step("beq", 0, 1, 0, 1, 10, 9, 9, 4);
    chk("beq.lit", alu_value, 32'd1);
    step("bne", 0, 1, 0, 1, 11, 9, 9, 4);
    chk("bne.lit", alu_value, 32'd0);

    for (int i = 0; i < 4; i++) begin
      step("b2b", 0, 1, 0, 1, 0, 32'(i * 100), 32'd1, 4'(i));
      chk("b2b.id", {28'd0, inputalu_rob_id}, 32'(i));
    end
    step("b2b.end", 0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 1, 0, 40, 2, 5);
    chk("stall.lit", {31'd0, alu_ready}, 32'd0);
    step("stall.rise", 0, 1, 0, 1, 0, 40, 2, 5);
    chk("stall.rise.lit", alu_value, 32'd42);
    step("hold", 0, 0, 0, 1, 1, 3, 3, 9);
    step("hold2", 0, 0, 1, 0, 2, 0, 0, 0);
    chk("hold.lit", alu_value, 32'd42);

    step("idle2", 0, 1, 0, 0, 0, 0, 0, 0);
    step("shot_clear", 0, 1, 1, 1, 0, 1, 1, 6);
    chk("shot_clear.lit", {31'd0, alu_ready}, 32'd0);
    step("shot", 0, 1, 0, 1, 4, 32'hF0F0, 32'h0FF0, 7);
    step("clear_after", 0, 1, 1, 0, 0, 0, 0, 0);
    step("shot2", 0, 1, 0, 1, 3, 1, 2, 8);
    step("rst_shot", 1, 1, 0, 1, 0, 5, 5, 9);
    chk("rst_shot.lit", alu_value, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000 | a;
      step("rand", ($urandom_range(0, 40) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), a, b, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
